fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of requesters (>=2); DATA_WIDTH, default 32, data bits per requester; MAX_BURST, default 4, beats per grant lock (>=1).
REQ-002 i_clk  in  1  sole clock; all logic on rising edge.
REQ-003 i_rst_n  in  1  reset, synchronous, active-low.
REQ-004 i_valid_s  in  NUM_REQ  per-requester write request.
REQ-005 i_datain  in  NUM_REQ*DATA_WIDTH  flattened requester data; slice k = bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-006 o_ready_s  out  NUM_REQ  per-requester accept; at most one bit high.
REQ-007 o_valid_m  out  1  write request toward FIFO.
REQ-008 i_ready_m  in  1  FIFO can accept (not full).
REQ-009 o_dataout  out  DATA_WIDTH  write data toward FIFO.
REQ-010 o_grant  out  NUM_REQ  one-hot current grant; zero when no requester valid.
REQ-011 o_grant_id  out  max(1,$clog2(NUM_REQ))  binary index of current grant; 0 when o_grant is zero.

Function
REQ-012 Transfer in: beat from k SHALL occur when i_valid_s[k] && o_ready_s[k] at a clock edge.
REQ-013 o_ready_s[k] SHALL equal o_grant[k] && (!o_valid_m || i_ready_m), combinational.
REQ-014 Output stage SHALL be one register: on transfer in, o_dataout <= slice k, o_valid_m <= 1; else if i_ready_m, o_valid_m <= 0; o_dataout holds otherwise.
REQ-015 Latency: accepted data SHALL appear on o_dataout/o_valid_m exactly one cycle after acceptance; sustained throughput 1 beat/cycle when i_ready_m=1.
REQ-016 While o_valid_m=1 and i_ready_m=0, o_dataout and o_valid_m SHALL remain stable.
REQ-017 Round-robin: rr_ptr (index register) SHALL define highest priority; winner = first valid requester at rr_ptr, rr_ptr+1, ... wrapping NUM_REQ-1 -> 0.
REQ-018 FSM states SHALL be S_ARB (grant from round-robin each cycle) and S_LOCK (grant fixed to lock_id).
REQ-019 In S_ARB, after a transfer from w, rr_ptr SHALL become (w+1) mod NUM_REQ; no transfer -> rr_ptr unchanged.
REQ-020 Grant SHALL change only on cycles without a stalled handshake; new winners may appear in the same cycle a requester raises valid.
REQ-021 A requester dropping i_valid_s without a transfer SHALL lose its grant immediately with no side effect on rr_ptr.

Reset
REQ-022 On i_rst_n=0 at a clock edge: o_valid_m=0, o_dataout=0, rr_ptr=0, state=S_ARB, beat_cnt=0, lock_id=0.
REQ-023 Reset mid-operation SHALL discard the pending output beat and any lock; o_grant/o_ready_s then follow REQ-013/017 from rr_ptr=0.

Configuration
REQ-024 Macro FIFO_ARB_BURST_EN SHALL enable burst lock; undefined: S_LOCK unreachable, beat_cnt absent, behaviour per REQ-017..019 only.
REQ-025 With FIFO_ARB_BURST_EN: first transfer from w in S_ARB enters S_LOCK with lock_id=w, beat_cnt=1, unless MAX_BURST=1.
REQ-026 In S_LOCK each transfer increments beat_cnt (width $clog2(MAX_BURST+1)); on reaching MAX_BURST, or lock_id's i_valid_s=0 while not stalled, SHALL return to S_ARB with rr_ptr=(lock_id+1) mod NUM_REQ, beat_cnt=0.
REQ-027 In S_LOCK other requesters SHALL see o_ready_s=0 regardless of their valid.

Structure
REQ-028 Package fifo_arb_pkg SHALL hold the state enum (S_ARB, S_LOCK) and ID-width helper function.
REQ-029 Sub-module rr_arb_pick SHALL implement the combinational rotate-priority pick (requests, rr_ptr -> one-hot, id, any).

Verification (NUM_REQ=4, DATA_WIDTH=32, MAX_BURST=4; data slice k = 32'hA0+k per beat count)
REQ-030 Reset: assert i_rst_n=0 one edge with all valid=1 -> o_valid_m=0, o_dataout=0, then o_grant=4'b0001, o_ready_s=4'b0001.
REQ-031 Macro off, all valid, i_ready_m=1 -> acceptance order 0,1,2,3,0; o_dataout follows one cycle later, o_valid_m continuously 1.
REQ-032 Backpressure: i_ready_m=0 for 3 cycles with o_valid_m=1 -> o_ready_s=0, o_dataout stable; i_ready_m=1 -> resume, no beat lost or duplicated.
REQ-033 Only requester 2 valid for 8 cycles -> 8 beats accepted consecutively, o_grant_id=2 throughout.
REQ-034 Macro on, req0 and req1 valid -> 4 beats from 0 then 4 from 1; req0 drops valid after 2 beats -> req1 granted next cycle, rr_ptr=1.
REQ-035 Macro on, i_rst_n=0 during beat 2 of lock -> o_valid_m=0, state S_ARB, next grant to requester 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
// The state enum is used only when FIFO_ARB_BURST_EN is defined.
package fifo_arb_pkg;

    typedef enum logic {
        S_ARB  = 1'b0,
        S_LOCK = 1'b1
    } arb_state_t;

    // Width of a binary requester index, never less than one bit.
    function automatic int id_width(input int n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational rotate-priority pick: the first requester found at ptr,
// ptr+1, ... wrapping past NUM_REQ-1 back to 0 wins.
module rr_arb_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     id,
    output logic               any
);

    int             idx;
    logic [IDW-1:0] idx_b;

    // Walk the requesters in priority order and keep the first hit.
    always_comb begin
        grant = '0;
        id    = '0;
        any   = 1'b0;
        idx   = 0;
        idx_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_b = IDW'(idx);
            if (!any && req[idx_b]) begin
                any          = 1'b1;
                grant[idx_b] = 1'b1;
                id           = idx_b;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter merging NUM_REQ write streams into one FIFO write port
// through a single registered output stage.
// Optional macro FIFO_ARB_BURST_EN: a winner keeps the grant for up to
// MAX_BURST beats (S_LOCK) before round-robin resumes.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_valid_s,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_datain,
    output logic [NUM_REQ-1:0]            o_ready_s,
    output logic                          o_valid_m,
    input  logic                          i_ready_m,
    output logic [DATA_WIDTH-1:0]         o_dataout,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic [id_width(NUM_REQ)-1:0]  o_grant_id
);

    localparam int IDW = id_width(NUM_REQ);

    logic [IDW-1:0]        rr_ptr;
    logic [NUM_REQ-1:0]    pick_grant;
    logic [IDW-1:0]        pick_id;
    logic                  pick_any;
    logic [NUM_REQ-1:0]    grant;
    logic [IDW-1:0]        grant_id;
    logic                  can_accept;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] sel_data;

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] w);
        if (int'(w) >= NUM_REQ - 1) return '0;
        return w + 1'b1;
    endfunction

    rr_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req   (i_valid_s),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .id    (pick_id),
        .any   (pick_any)
    );

`ifdef FIFO_ARB_BURST_EN
    localparam int             BCW       = $clog2(MAX_BURST + 1);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);

    arb_state_t     state;
    logic [IDW-1:0] lock_id;
    logic [BCW-1:0] beat_cnt;
    logic           lock_valid;
    logic           stalled;

    assign lock_valid = i_valid_s[lock_id];
    assign stalled    = o_valid_m && !i_ready_m;

    // Grant is pinned to the lock owner in S_LOCK; it is withdrawn (not
    // passed on) while the owner is idle, so nobody else slips in mid-lock.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        if (state == S_LOCK) begin
            if (lock_valid) begin
                grant[lock_id] = 1'b1;
                grant_id       = lock_id;
            end
        end else if (pick_any) begin
            grant    = pick_grant;
            grant_id = pick_id;
        end
    end

    // Arbitration FSM: round-robin pointer, lock owner and beat counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= S_ARB;
            rr_ptr   <= '0;
            lock_id  <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                S_ARB: begin
                    if (xfer) begin
                        rr_ptr <= next_idx(grant_id);
                        if (MAX_BURST > 1) begin
                            state    <= S_LOCK;
                            lock_id  <= grant_id;
                            beat_cnt <= BCW'(1);
                        end
                    end
                end
                S_LOCK: begin
                    if (xfer) begin
                        if (beat_cnt == LAST_BEAT) begin
                            state    <= S_ARB;
                            rr_ptr   <= next_idx(lock_id);
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end else if (!lock_valid && !stalled) begin
                        // Owner went idle with the output free: end the burst early.
                        state    <= S_ARB;
                        rr_ptr   <= next_idx(lock_id);
                        beat_cnt <= '0;
                    end
                end
                default: state <= S_ARB;
            endcase
        end
    end
`else
    // Plain round-robin: grant straight from the pick each cycle.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        if (pick_any) begin
            grant    = pick_grant;
            grant_id = pick_id;
        end
    end

    // Round-robin pointer moves past the winner after each accepted beat.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= next_idx(grant_id);
        end
    end
`endif

    assign can_accept = !o_valid_m || i_ready_m;
    assign o_ready_s  = grant & {NUM_REQ{can_accept}};
    assign xfer       = |(i_valid_s & o_ready_s);
    assign o_grant    = grant;
    assign o_grant_id = grant_id;

    // One-hot mux of the granted requester's data slice.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) sel_data = i_datain[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Output register: load on accept, drain when the FIFO takes the beat,
    // hold everything while stalled.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid_m <= 1'b0;
            o_dataout <= '0;
        end else if (xfer) begin
            o_valid_m <= 1'b1;
            o_dataout <= sel_data;
        end else if (i_ready_m) begin
            o_valid_m <= 1'b0;
        end
    end

endmodule
